// File: rtl/game_sequencer.sv
// Game sequencer: start-button conditioning, one-second prescaler and the
// IDLE -> PRE countdown -> PLAY -> DONE flow, with registered display outputs.
module game_sequencer #(
  parameter int CLK_HZ       = 100000000,
  parameter int PRE_SECONDS  = 5,
  parameter int GAME_SECONDS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       hit_in,
  output logic       game_begin,
  output logic [2:0] count_down,
  output logic [4:0] time_left,
  output logic [5:0] score,
  output logic       game_over
);

  localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [2:0]      CD_INIT  = 3'(PRE_SECONDS);
  localparam logic [4:0]      TL_INIT  = 5'(GAME_SECONDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;

  logic          sync1_q, sync2_q, dly_q;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;
  logic          start_edge;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [2:0]    cd_q, cd_d;
  logic [4:0]    tl_q, tl_d;
  logic [5:0]    score_q, score_d;
  logic          gb_q, gb_d;
  logic          go_q, go_d;

  // Score increment that sticks at the 6-bit maximum.
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  // The edge detector is only armed once a genuine (post-reset) low level of
  // the synchronised button has been seen; fill_q marks when sync2_q starts
  // carrying a real sample, so a button held through reset never fires.
  assign armed_d    = armed_q | (fill_q[1] & ~sync2_q);
  assign start_edge = sync2_q & ~dly_q & armed_q;
  assign tick       = (pre_q == PRE_LAST);

  // Button synchroniser, delay flop and arming logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  // Next-state, prescaler and output-register values.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    tl_d    = tl_q;
    score_d = score_q;
    gb_d    = gb_q;
    go_d    = go_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);

    case (state_q)
      IDLE: begin
        cd_d    = CD_INIT;
        tl_d    = TL_INIT;
        score_d = 6'd0;
        gb_d    = 1'b0;
        go_d    = 1'b0;
        if (start_edge) begin
          state_d = PRE;
        end
      end
      PRE: begin
        if (tick) begin
          if (cd_q == 3'd1) begin
            state_d = PLAY;
            cd_d    = 3'd0;
            gb_d    = 1'b1;
          end else begin
            cd_d = cd_q - 3'd1;
          end
        end
      end
      PLAY: begin
        // A hit on the final tick still lands before the score freezes.
        if (hit_in) begin
          score_d = sat_inc6(score_q);
        end
        if (tick) begin
          if (tl_q == 5'd1) begin
            state_d = DONE;
            tl_d    = 5'd0;
            go_d    = 1'b1;
          end else begin
            tl_d = tl_q - 5'd1;
          end
        end
      end
      DONE: begin
        if (start_edge) begin
          state_d = PRE;
          score_d = 6'd0;
          cd_d    = CD_INIT;
          tl_d    = TL_INIT;
          gb_d    = 1'b0;
          go_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restarting the prescaler on entry makes every state's first second full length.
    if (state_d != state_q) begin
      pre_d = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prescaler and registered display/status values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      cd_q    <= CD_INIT;
      tl_q    <= TL_INIT;
      score_q <= 6'd0;
      gb_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cd_q    <= cd_d;
      tl_q    <= tl_d;
      score_q <= score_d;
      gb_q    <= gb_d;
      go_q    <= go_d;
    end
  end

  assign game_begin = gb_q;
  assign count_down = cd_q;
  assign time_left  = tl_q;
  assign score      = score_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized traffic,
// compared each cycle against a phase/elapsed-time reference model.
module tb_game_sequencer;

  localparam int CLK_HZ = 4;
  localparam int PRE_S  = 5;
  localparam int GAME_S = 30;
  localparam logic [15:0] IDLE_OUT = {1'b0, 3'd5, 5'd30, 6'd0, 1'b0};

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_PLAY = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       hit_in;
  logic       game_begin;
  logic [2:0] count_down;
  logic [4:0] time_left;
  logic [5:0] score;
  logic       game_over;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_mode;
  int m_el;
  int m_hits;
  int edge_no;
  bit m_prev;
  bit m_prev_ok;
  int due_q[$];

  game_sequencer #(
    .CLK_HZ(CLK_HZ),
    .PRE_SECONDS(PRE_S),
    .GAME_SECONDS(GAME_S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_btn(start_btn),
    .hit_in(hit_in),
    .game_begin(game_begin),
    .count_down(count_down),
    .time_left(time_left),
    .score(score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  assign obs = {game_begin, count_down, time_left, score, game_over};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [15:0] model_out();
    int cd, tl, sc;
    bit gb, go;
    cd = PRE_S; tl = GAME_S; sc = 0; gb = 1'b0; go = 1'b0;
    case (m_mode)
      M_PRE:  cd = PRE_S - m_el / CLK_HZ;
      M_PLAY: begin
        cd = 0; tl = GAME_S - m_el / CLK_HZ;
        sc = (m_hits > 63) ? 63 : m_hits; gb = 1'b1;
      end
      M_DONE: begin
        cd = 0; tl = 0; sc = (m_hits > 63) ? 63 : m_hits; gb = 1'b1; go = 1'b1;
      end
      default: ;
    endcase
    return {gb, 3'(cd), 5'(tl), 6'(sc), go};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_el = 0; m_hits = 0;
    m_prev = 1'b0; m_prev_ok = 1'b0;
    due_q.delete();
  endtask

  // One rising edge: a sampled 0->1 button change takes effect two edges later.
  task automatic model_edge(input bit sb, input bit hit);
    bit start;
    start = 1'b0;
    edge_no++;
    while (due_q.size() > 0 && due_q[0] == edge_no) begin
      start = 1'b1;
      void'(due_q.pop_front());
    end
    if (m_prev_ok && sb && !m_prev) due_q.push_back(edge_no + 2);
    m_prev = sb; m_prev_ok = 1'b1;
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_PRE; m_el = 0; m_hits = 0; end
      M_PRE: begin
        m_el++;
        if (m_el == PRE_S * CLK_HZ) begin m_mode = M_PLAY; m_el = 0; end
      end
      M_PLAY: begin
        if (hit) m_hits++;
        m_el++;
        if (m_el == GAME_S * CLK_HZ) m_mode = M_DONE;
      end
      default: if (start) begin m_mode = M_PRE; m_el = 0; m_hits = 0; end
    endcase
  endtask

  // Drive inputs at the falling edge, clock once, return at the next falling edge.
  task automatic step(input bit sb, input bit hit);
    start_btn = sb; hit_in = hit;
    @(posedge clk);
    model_edge(sb, hit);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start_btn = 1'b0; hit_in = 1'b0;
    edge_no = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++; $display("FAIL reset_hold: got %h want %h", obs, IDLE_OUT);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i[0]);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL idle_hits cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++; $display("FAIL idle_after_release: got %h want %h", obs, IDLE_OUT);
    end
  endtask

  task automatic test_pre();
    int n, first_cd4;
    step(1'b1, 1'b0);
    n = 1; first_cd4 = 0;
    while (game_begin !== 1'b1 && n < 40) begin
      step(1'b0, (n % 3) == 0);
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL pre_model edge %0d: got %h want %h", n, obs, model_out());
      end
      if (first_cd4 == 0 && count_down == 3'd4) first_cd4 = n;
    end
    checks++;
    if (first_cd4 != 7) begin
      errors++; $display("FAIL pre_first_decrement: got edge %0d want edge 7", first_cd4);
    end
    checks++;
    if (n != 23 || count_down !== 3'd0) begin
      errors++; $display("FAIL pre_to_play: got edge %0d cd %0d want edge 23 cd 0", n, count_down);
    end
  endtask

  task automatic test_play_saturate();
    int n;
    n = 0;
    while (game_over !== 1'b1 && n < 200) begin
      step(1'b0, (n < 105) && ((n % 3) != 2));
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL play_model cyc %0d: got %h want %h", n, obs, model_out());
      end
    end
    checks++;
    if (n != 120 || time_left !== 5'd0 || score !== 6'd63) begin
      errors++;
      $display("FAIL play_expiry: got cyc %0d tl %0d score %0d want cyc 120 tl 0 score 63", n, time_left, score);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL done_hold cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
  endtask

  task automatic test_restart_done();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (game_over !== 1'b1 || score !== 6'd63) begin
      errors++; $display("FAIL restart_latency: got go %0b score %0d want go 1 score 63", game_over, score);
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++; $display("FAIL restart_pre_entry: got %h want %h", obs, IDLE_OUT);
    end
  endtask

  task automatic test_ignored();
    int n;
    bit hitmap[120];
    int hit_pos[9];
    hit_pos = '{3, 17, 44, 60, 61, 88, 100, 118, 119};
    for (int i = 0; i < 120; i++) hitmap[i] = 1'b0;
    for (int i = 0; i < 9; i++) hitmap[hit_pos[i]] = 1'b1;
    n = 0;
    while (game_begin !== 1'b1 && n < 30) begin
      step(1'b0, 1'b1);
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL pre_hits cyc %0d: got %h want %h", n, obs, model_out());
      end
    end
    checks++;
    if (n != 20) begin
      errors++; $display("FAIL pre_length: got %0d cycles want 20", n);
    end
    n = 0;
    while (game_over !== 1'b1 && n < 200) begin
      step((n == 40) || (n >= 50 && n <= 55), (n < 120) ? hitmap[n] : 1'b0);
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL play_ignore cyc %0d: got %h want %h", n, obs, model_out());
      end
    end
    checks++;
    if (n != 120 || score !== 6'd9) begin
      errors++; $display("FAIL play_final_hit: got cyc %0d score %0d want cyc 120 score 9", n, score);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL done_hits cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n = 0;
    while (game_begin !== 1'b1 && n < 30) begin
      step(1'b0, 1'b0);
      n++;
    end
    n = 0;
    while (time_left !== 5'd17 && n < 200) begin
      step(1'b0, n < 9);
      n++;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL midplay cyc %0d: got %h want %h", n, obs, model_out());
      end
    end
    checks++;
    if (n != 52 || score !== 6'd9) begin
      errors++; $display("FAIL midplay_point: got cyc %0d score %0d want cyc 52 score 9", n, score);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++; $display("FAIL async_reset_between_edges: got %h want %h", obs, IDLE_OUT);
    end
    start_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL held_btn_model cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++; $display("FAIL held_btn_no_start: got %h want %h", obs, IDLE_OUT);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    checks++;
    if (count_down !== 3'd4 || obs !== model_out()) begin
      errors++; $display("FAIL fresh_press_after_reset: got cd %0d want 4", count_down);
    end
  endtask

  task automatic test_random();
    bit btn;
    btn = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 29) == 0) btn = ~btn;
      step(btn, $urandom_range(0, 2) == 0);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pre();
    test_play_saturate();
    test_restart_done();
    test_ignored();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
